board_text_renderer: RTL

//  Parametrised successor of the board text printer: renders an N x N tile grid as ASCII

---
 rtl/board_text_renderer.sv | 254 +++++++++++++++++++++++++
 1 files changed

// File: rtl/board_text_renderer.sv
// Renders a snapshotted N x N tile board as framed ASCII text, one char per valid/ready transfer.
// Optional BTR_LZ_BLANK_EN: leading zeros of tile values print as spaces.
module board_text_renderer #(
  parameter int unsigned N      = 4,
  parameter int unsigned VAL_W  = 20,
  parameter int unsigned DIGITS = 4,
  parameter int unsigned CELL_W = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [N*N*VAL_W-1:0] board,
  output logic [7:0]           char_out,
  output logic                 char_valid,
  input  logic                 char_ready,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned LW       = N * CELL_W + 1;
  localparam int unsigned NLINES   = 4 * N + 1;
  localparam int unsigned LINE_W   = $clog2(NLINES + 1);
  localparam int unsigned COL_W    = $clog2(LW + 2);
  localparam int unsigned CELL_IW  = $clog2(N + 1);
  localparam int unsigned CC_W     = $clog2(CELL_W);
  localparam int unsigned TILE_W   = $clog2(N);
  localparam int unsigned BIT_W    = $clog2(VAL_W);

  localparam logic [LINE_W-1:0]  LastLine = LINE_W'(NLINES);
  localparam logic [COL_W-1:0]   ColLf    = COL_W'(LW);
  localparam logic [COL_W-1:0]   ColCr    = COL_W'(LW + 1);
  localparam logic [CC_W-1:0]    CcLast   = CC_W'(CELL_W - 1);
  localparam logic [CC_W-1:0]    CcDig0   = CC_W'(2);
  localparam logic [CC_W-1:0]    CcDigEnd = CC_W'(DIGITS + 2);
  localparam logic [CELL_IW-1:0] CellN    = CELL_IW'(N);
  localparam logic [BIT_W-1:0]   BitLast  = BIT_W'(VAL_W - 1);
  localparam logic [TILE_W-1:0]  TileLast = TILE_W'(N - 1);
  localparam logic [63:0]        Limit    = 64'(10 ** DIGITS);

`ifdef BTR_LZ_BLANK_EN
  localparam logic BlankEn = 1'b1;
`else
  localparam logic BlankEn = 1'b0;
`endif

  typedef enum logic [1:0] {StIdle, StEmit, StConv, StDone} state_e;

  state_e               state_q, state_d;
  logic [7:0]           char_q, char_d;
  logic                 valid_q, valid_d, busy_q, busy_d, done_q, done_d;
  logic [LINE_W-1:0]    line_q, line_d;
  logic [COL_W-1:0]     col_q, col_d;
  logic [CC_W-1:0]      cc_q, cc_d;
  logic [CELL_IW-1:0]   cell_q, cell_d;
  logic                 row_rdy_q, row_rdy_d;
  logic [VAL_W-1:0]     snap_q [N][N];
  logic [VAL_W-1:0]     snap_d [N][N];
  logic [3:0]           bcd_q [N][DIGITS];
  logic [3:0]           bcd_d [N][DIGITS];
  logic [N-1:0]         ovf_q, ovf_d;
  logic [VAL_W-1:0]     sh_q, sh_d;
  logic [DIGITS*4-1:0]  acc_q, acc_d, adj, acc_step;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [TILE_W-1:0]    tile_q, tile_d;

  logic [TILE_W-1:0] row, cidx;
  logic [1:0]        lsel;
  logic [7:0]        gen_char;
  logic [3:0]        dig;
  logic              blank, lz, slot_free;

  assign row  = line_q[TILE_W+1:2];
  assign lsel = line_q[1:0];
  assign cidx = (cell_q < CellN) ? cell_q[TILE_W-1:0] : '0;

  // Character at the current generator position (line_q, col_q).
  always_comb begin
    gen_char = 8'h20;
    dig      = 4'h0;
    blank    = 1'b0;
    lz       = 1'b1;
    for (int j = 0; j < DIGITS; j++) begin
      if (bcd_q[cidx][j] != 4'h0) lz = 1'b0;
      if (cc_q == CC_W'(j + 2)) begin
        dig   = bcd_q[cidx][j];
        blank = lz;
      end
    end
    if (line_q == LastLine)   gen_char = col_q[0] ? 8'h0d : 8'h0a;
    else if (col_q == ColLf)  gen_char = 8'h0a;
    else if (col_q == ColCr)  gen_char = 8'h0d;
    else if (lsel == 2'd0)    gen_char = 8'h2d;
    else if (cc_q == '0)      gen_char = 8'h7c;
    else if (lsel == 2'd2 && cc_q >= CcDig0 && cc_q < CcDigEnd) begin
      if (ovf_q[cidx])            gen_char = 8'h2a;
      else if (blank && BlankEn)  gen_char = 8'h20;
      else                        gen_char = 8'h30 | {4'h0, dig};
    end
  end

  always_comb begin
    state_d   = state_q;
    char_d    = char_q;
    valid_d   = valid_q;
    busy_d    = busy_q;
    done_d    = done_q;
    line_d    = line_q;
    col_d     = col_q;
    cc_d      = cc_q;
    cell_d    = cell_q;
    row_rdy_d = row_rdy_q;
    snap_d    = snap_q;
    bcd_d     = bcd_q;
    ovf_d     = ovf_q;
    sh_d      = sh_q;
    acc_d     = acc_q;
    bit_d     = bit_q;
    tile_d    = tile_q;
    adj       = acc_q;
    for (int j = 0; j < DIGITS; j++) begin
      if (adj[j*4 +: 4] >= 4'd5) adj[j*4 +: 4] = adj[j*4 +: 4] + 4'd3;
    end
    acc_step  = {adj[DIGITS*4-2:0], sh_q[VAL_W-1]};
    slot_free = !valid_q || char_ready;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) snap_d[r][c] = board[(r*N+c)*VAL_W +: VAL_W];
          end
          // First '-' goes out immediately; generator resumes at column 1.
          state_d   = StEmit;
          busy_d    = 1'b1;
          char_d    = 8'h2d;
          valid_d   = 1'b1;
          line_d    = '0;
          col_d     = COL_W'(1);
          cc_d      = CC_W'(1);
          cell_d    = '0;
          row_rdy_d = 1'b0;
        end
      end
      StEmit: begin
        if (slot_free) begin
          valid_d = 1'b0;
          if (line_q == LastLine && col_q == COL_W'(4)) begin
            state_d = StDone;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else if (lsel == 2'd2 && col_q == '0 && !row_rdy_q) begin
            state_d = StConv;
            tile_d  = '0;
            bit_d   = '0;
            acc_d   = '0;
            sh_d    = snap_q[row][0];
          end else begin
            char_d  = gen_char;
            valid_d = 1'b1;
            if (line_q == LastLine) begin
              col_d = col_q + 1'b1;
            end else if (col_q == ColCr) begin
              col_d     = '0;
              cc_d      = '0;
              cell_d    = '0;
              line_d    = line_q + 1'b1;
              row_rdy_d = 1'b0;
            end else begin
              col_d = col_q + 1'b1;
              if (cc_q == CcLast) begin
                cc_d   = '0;
                cell_d = cell_q + 1'b1;
              end else begin
                cc_d = cc_q + 1'b1;
              end
            end
          end
        end
      end
      StConv: begin
        // One double-dabble step per cycle; the overflow flag comes from a direct compare.
        sh_d  = sh_q << 1;
        acc_d = acc_step;
        bit_d = bit_q + 1'b1;
        if (bit_q == BitLast) begin
          for (int j = 0; j < DIGITS; j++) bcd_d[tile_q][j] = acc_step[(DIGITS-1-j)*4 +: 4];
          ovf_d[tile_q] = 64'(snap_q[row][tile_q]) >= Limit;
          if (tile_q == TileLast) begin
            state_d   = StEmit;
            row_rdy_d = 1'b1;
          end else begin
            tile_d = tile_q + 1'b1;
            bit_d  = '0;
            acc_d  = '0;
            sh_d   = snap_q[row][tile_q + 1'b1];
          end
        end
      end
      StDone: begin
        done_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      char_q    <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      line_q    <= '0;
      col_q     <= '0;
      cc_q      <= '0;
      cell_q    <= '0;
      row_rdy_q <= 1'b0;
      ovf_q     <= '0;
      sh_q      <= '0;
      acc_q     <= '0;
      bit_q     <= '0;
      tile_q    <= '0;
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) snap_q[r][c] <= '0;
        for (int j = 0; j < DIGITS; j++) bcd_q[r][j] <= '0;
      end
    end else begin
      state_q   <= state_d;
      char_q    <= char_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      line_q    <= line_d;
      col_q     <= col_d;
      cc_q      <= cc_d;
      cell_q    <= cell_d;
      row_rdy_q <= row_rdy_d;
      ovf_q     <= ovf_d;
      sh_q      <= sh_d;
      acc_q     <= acc_d;
      bit_q     <= bit_d;
      tile_q    <= tile_d;
      snap_q    <= snap_d;
      bcd_q     <= bcd_d;
    end
  end

  assign char_out   = char_q;
  assign char_valid = valid_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
